// File: rtl/end_screen_half_color_encoder.sv
`timescale 1ns/1ps
// end_screen_half_color_encoder
// Encodes a 12-bit {R,G,B} pixel into the index of the nearest entry (L1
// distance) of a loadable 16-entry palette. The search is sequential, one
// entry per clock, with valid/ready handshakes on input and output.
//
// Ports:
//   Clk, Reset           clock (rising edge), synchronous active-high reset
//   wr_en/wr_addr/wr_data palette write port, honoured only while idle
//   busy                 high whenever the encoder is not idle
//   in_valid/in_ready/in_rgb      pixel input handshake
//   out_valid/out_ready           result handshake
//   out_index/out_dist            winning index and its L1 distance
module end_screen_half_color_encoder #(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = 4,
    parameter bit EXACT_EXIT  = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [11:0]      wr_data,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_rgb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [5:0]       out_dist
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    state_t           state_q, state_d;
    logic [11:0]      pal_q [NUM_ENTRIES];
    logic [11:0]      pal_d [NUM_ENTRIES];
    logic [11:0]      pix_q, pix_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [5:0]       best_dist_q, best_dist_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic [5:0]       out_dist_q, out_dist_d;

    function automatic logic [4:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

    // Distance of the entry under test from the latched pixel
    logic [11:0]      cur_entry;
    logic [5:0]       cur_dist;
    logic             better;
    logic [5:0]       win_dist;
    logic [IDX_W-1:0] win_idx;

    assign cur_entry = pal_q[idx_q];
    assign cur_dist  = 6'(abs_diff(cur_entry[11:8], pix_q[11:8]))
                     + 6'(abs_diff(cur_entry[7:4],  pix_q[7:4]))
                     + 6'(abs_diff(cur_entry[3:0],  pix_q[3:0]));
    // Strict compare: on a tie the earlier (lower) index stays the winner
    assign better    = cur_dist < best_dist_q;
    assign win_dist  = better ? cur_dist : best_dist_q;
    assign win_idx   = better ? idx_q    : best_idx_q;

    always_comb begin
        state_d     = state_q;
        pal_d       = pal_q;
        pix_d       = pix_q;
        idx_d       = idx_q;
        best_dist_d = best_dist_q;
        best_idx_d  = best_idx_q;
        out_index_d = out_index_q;
        out_dist_d  = out_dist_q;
        case (state_q)
            S_IDLE: begin
                // A write in the accept cycle lands before the first compare
                if (wr_en) pal_d[wr_addr] = wr_data;
                if (in_valid) begin
                    pix_d       = in_rgb;
                    idx_d       = '0;
                    best_dist_d = 6'd63;
                    best_idx_d  = '0;
                    state_d     = S_SEARCH;
                end
            end
            S_SEARCH: begin
                best_dist_d = win_dist;
                best_idx_d  = win_idx;
                if (idx_q == LAST_IDX || (EXACT_EXIT && cur_dist == 6'd0)) begin
                    out_index_d = win_idx;
                    out_dist_d  = win_dist;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < NUM_ENTRIES; i++) pal_q[i] <= 12'h000;
            pix_q       <= 12'h000;
            idx_q       <= '0;
            best_dist_q <= 6'd63;
            best_idx_q  <= '0;
            out_index_q <= '0;
            out_dist_q  <= 6'd0;
        end else begin
            state_q     <= state_d;
            pal_q       <= pal_d;
            pix_q       <= pix_d;
            idx_q       <= idx_d;
            best_dist_q <= best_dist_d;
            best_idx_q  <= best_idx_d;
            out_index_q <= out_index_d;
            out_dist_q  <= out_dist_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_IDLE) && !Reset;
    assign out_valid = (state_q == S_DONE);
    assign out_index = out_index_q;
    assign out_dist  = out_dist_q;

endmodule
